uart_32bit_rx: RTL and testbench
================================

UART_32BIT_RX -- requirements
Module: uart_32bit_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all logic on rising edge); reset input 1 (synchronous, active-high).
REQ-002 Parameter CLK_FREQUENCY SHALL default to 100_000_000 and give the clk frequency in Hz.
REQ-003 Parameter BAUD_RATE SHALL default to 115200 and give the serial bit rate in bit/s.
REQ-004 Derived constant CLKS_PER_BIT SHALL equal CLK_FREQUENCY/BAUD_RATE (integer division; 868 at defaults); it SHALL be at least 4.
REQ-005 Port rx SHALL be an input, 1 bit: asynchronous serial line, idle high.
REQ-006 Port one_byte SHALL be an input, 1 bit: 1 = a word is a single byte; 0 = a word is four bytes.
REQ-007 Port data_out SHALL be an output, 32 bits: last completed word.
REQ-008 Port data_valid SHALL be an output, 1 bit: one-cycle pulse, data_out updated.
REQ-009 Port frame_error SHALL be an output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-010 Port rx_busy SHALL be an output, 1 bit: high while a byte frame is in progress (state not IDLE).

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-012 Frame format SHALL be 8N1: 1 start (0), 8 data bits LSB first, 1 stop (1); no parity.
REQ-013 The byte FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 In IDLE, rx_s==0 SHALL cause a move to START with the bit counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles, rx_s is sampled; 0 -> DATA (counter cleared); 1 -> IDLE, glitch ignored, no output pulse.
REQ-016 DATA: every CLKS_PER_BIT cycles, one bit SHALL be sampled into shift-register bit index 0..7 (LSB first); after bit 7 -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, rx_s is sampled; 1 -> byte accepted; 0 -> frame_error pulse, byte discarded. Either case -> IDLE next cycle.
REQ-018 Next start-bit detection SHALL be possible in the cycle immediately after the STOP sample (back-to-back frames).
REQ-019 The word assembler SHALL keep a 2-bit byte index k (0..3); accepted byte k goes to word bits [8k+7:8k].
REQ-020 one_byte SHALL be sampled only when byte 0 is accepted; changes during a word are ignored.
REQ-021 Sampled one_byte==1: the word completes at byte 0, with bits [31:8]=0.
REQ-022 Sampled one_byte==0: the word completes at byte 3.
REQ-023 On word completion, data_out SHALL load the assembled word and data_valid SHALL pulse high exactly one cycle, in the cycle after the accepting STOP sample.
REQ-024 After word completion, k SHALL return to 0.
REQ-025 data_out SHALL hold its value until the next completion.
REQ-026 frame_error SHALL pulse in the cycle after the failing STOP sample.
REQ-027 A frame error SHALL reset k to 0 and discard the partial word; data_out is unchanged and data_valid does not pulse.
REQ-028 There SHALL be no inter-byte timeout; a partial word waits indefinitely.
REQ-029 data_valid and frame_error SHALL never be high in the same cycle.

Reset
REQ-030 On reset, the following SHALL apply: FSM=IDLE, k=0, counters=0, shift register=0, synchronizer flops=1, data_out=0, data_valid=0, frame_error=0, rx_busy=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame on the next edge; no pulse is generated and the partial word is lost.
REQ-032 After reset deassertion, a line already low SHALL be treated as a start bit.

Verification (CLK_FREQUENCY=1600, BAUD_RATE=100 -> CLKS_PER_BIT=16)
REQ-033 Scenario: one_byte=0, send bytes 0x78,0x56,0x34,0x12 back-to-back -> single data_valid pulse, data_out=0x12345678, frame_error never high.
REQ-034 Scenario: one_byte=1, send 0xA5 -> data_valid pulse with data_out=0x000000A5, pulse in cycle after the stop-bit sample.
REQ-035 Scenario: one_byte=0, send 0x11,0x22, then a frame with stop bit 0, then 0x44,0x33,0x22,0x11 -> one frame_error pulse, then data_valid with data_out=0x11223344; data_out stays 0 before that.
REQ-036 Scenario: 4-cycle low glitch on idle rx -> no data_valid, no frame_error, rx_busy high at most CLKS_PER_BIT/2+3 cycles.
REQ-037 Scenario: reset pulsed during data bit 4 of byte 2, then a full 4-byte word 0xDEADBEEF sent -> data_out=0xDEADBEEF, no stale bytes.
REQ-038 Scenario: one_byte toggled 0->1 after byte 0 is accepted -> word still completes after 4 bytes.

Source files
------------

// File: rtl/uart_32bit_rx_if.sv
// Signal bundle between the 32-bit UART receiver and its user: serial line and
// word-size select in, assembled word with status pulses out.
interface uart_32bit_rx_if;
  logic        rx;
  logic        one_byte;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_error;
  logic        rx_busy;

  modport master (
    output rx, one_byte,
    input  data_out, data_valid, frame_error, rx_busy
  );

  modport slave (
    input  rx, one_byte,
    output data_out, data_valid, frame_error, rx_busy
  );
endinterface

// File: rtl/uart_32bit_rx.sv
// 8N1 UART receiver that packs accepted bytes little-endian into 32-bit words,
// or delivers single bytes when one_byte is set at the first byte of a word.
module uart_32bit_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115200
) (
  input logic            clk,
  input logic            reset,
  uart_32bit_rx_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic             rx_p0, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [23:0]      word;
  logic [1:0]       k;
  logic [31:0]      data_q;
  logic             valid_q, ferr_q;
  logic             half_tick, bit_tick;

  assign half_tick = (cnt == CNT_W'(HALF_BIT - 1));
  assign bit_tick  = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (half_tick) state_d = rx_s ? IDLE : DATA;
      DATA:  if (bit_tick && bit_idx == 3'd7) state_d = STOP;
      STOP:  if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0   <= 1'b1;
      rx_s    <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      word    <= '0;
      k       <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_p0   <= bus.rx;
      rx_s    <= rx_p0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        START: cnt <= half_tick ? '0 : cnt + CNT_W'(1);
        DATA: begin
          if (bit_tick) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            // Word size is latched implicitly: one_byte only matters while k==0.
            if (!rx_s) begin
              ferr_q <= 1'b1;
              k      <= '0;
            end else if (k == 2'd0 && bus.one_byte) begin
              data_q  <= {24'd0, shift};
              valid_q <= 1'b1;
            end else if (k == 2'd3) begin
              data_q  <= {shift, word};
              valid_q <= 1'b1;
              k       <= '0;
            end else begin
              word[{k, 3'b000} +: 8] <= shift;
              k                      <= k + 2'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_error = ferr_q;
  assign bus.rx_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_32bit_rx.sv
// Bench for uart_32bit_rx at 16 clocks per bit: directed scenarios plus random
// frames, all scored against a byte-level word-assembly model.
module tb_uart_32bit_rx;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset;
  uart_32bit_rx_if bus();

  uart_32bit_rx #(.CLK_FREQUENCY(1600), .BAUD_RATE(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int dv_count = 0, fe_count = 0, both_count = 0;
  int last_dv_cyc = 0, busy_run = 0, busy_max = 0;
  always @(negedge clk) begin
    if (bus.data_valid) begin
      dv_count++;
      last_dv_cyc = cyc;
    end
    if (bus.frame_error) fe_count++;
    if (bus.data_valid && bus.frame_error) both_count++;
    if (bus.rx_busy) busy_run++;
    else busy_run = 0;
    if (busy_run > busy_max) busy_max = busy_run;
  end

  int compared = 0, mismatched = 0;
  int frame_start = 0;

  // Reference: bytes accumulate little-endian; word size fixed by one_byte at byte 0.
  int          exp_dv = 0, exp_fe = 0, m_n = 0;
  logic [31:0] m_acc = '0, exp_data = '0;
  bit          m_single = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, input int ncyc);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    frame_start = cyc;
    for (int i = 0; i < ncyc; i++) begin
      bus.rx = f[i / CPB];
      @(negedge clk);
    end
    bus.rx = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) begin
      exp_fe++;
      m_n   = 0;
      m_acc = '0;
    end else begin
      if (m_n == 0) m_single = bus.one_byte;
      m_acc = m_acc | (32'(b) << (8 * m_n));
      m_n++;
      if (m_single || m_n == 4) begin
        exp_dv++;
        exp_data = m_acc;
        m_n      = 0;
        m_acc    = '0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    drive_frame(b, stop, FRAME);
    model_frame(b, stop);
    check("dv_count", 32'(dv_count), 32'(exp_dv));
    check("fe_count", 32'(fe_count), 32'(exp_fe));
    check("data_out", bus.data_out, exp_data);
  endtask

  task automatic do_reset(input logic line);
    @(negedge clk);
    reset  = 1'b1;
    bus.rx = line;
    cycles(2);
    reset    = 1'b0;
    m_n      = 0;
    m_acc    = '0;
    exp_data = '0;
  endtask

  int dv0, fe0;

  initial begin
    reset        = 1'b1;
    bus.rx       = 1'b1;
    bus.one_byte = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(2);
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_data_valid", 32'(bus.data_valid), 32'h0);
    check("rst_frame_error", 32'(bus.frame_error), 32'h0);
    check("rst_rx_busy", 32'(bus.rx_busy), 32'h0);

    // Four back-to-back bytes into one word
    dv0 = dv_count; fe0 = fe_count;
    send(8'h78, 1'b1); send(8'h56, 1'b1); send(8'h34, 1'b1); send(8'h12, 1'b1);
    check("w4_word", bus.data_out, 32'h12345678);
    check("w4_pulses", 32'(dv_count - dv0), 32'd1);
    check("w4_no_ferr", 32'(fe_count - fe0), 32'd0);

    // Single-byte mode and pulse timing relative to mid stop bit
    bus.one_byte = 1'b1;
    send(8'hA5, 1'b1);
    check("w1_word", bus.data_out, 32'h000000A5);
    check("w1_latency", 32'((last_dv_cyc >= frame_start + 152) && (last_dv_cyc <= frame_start + 158)), 32'd1);

    // Frame error discards the partial word
    do_reset(1'b1);
    bus.one_byte = 1'b0;
    fe0 = fe_count; dv0 = dv_count;
    send(8'h11, 1'b1); send(8'h22, 1'b1);
    send(8'h33, 1'b0);
    check("ferr_hold", bus.data_out, 32'h0);
    check("ferr_no_dv", 32'(dv_count - dv0), 32'd0);
    send(8'h44, 1'b1); send(8'h33, 1'b1); send(8'h22, 1'b1); send(8'h11, 1'b1);
    check("ferr_word", bus.data_out, 32'h11223344);
    check("ferr_pulses", 32'(fe_count - fe0), 32'd1);

    // Short low glitch on an idle line
    dv0 = dv_count; fe0 = fe_count;
    busy_max = 0;
    bus.rx = 1'b0;
    cycles(4);
    bus.rx = 1'b1;
    cycles(40);
    check("glitch_no_dv", 32'(dv_count - dv0), 32'd0);
    check("glitch_no_fe", 32'(fe_count - fe0), 32'd0);
    check("glitch_busy_bound", 32'(busy_max <= CPB / 2 + 3), 32'd1);
    check("glitch_seen", 32'(busy_max > 0), 32'd1);

    // Reset during data bit 4 of byte 2, then a clean word
    send(8'hEF, 1'b1); send(8'hBE, 1'b1);
    drive_frame(8'h5C, 1'b1, CPB + 4 * CPB + CPB / 2);
    do_reset(1'b1);
    check("abort_data_out", bus.data_out, 32'h0);
    send(8'hEF, 1'b1); send(8'hBE, 1'b1); send(8'hAD, 1'b1); send(8'hDE, 1'b1);
    check("abort_word", bus.data_out, 32'hDEADBEEF);

    // one_byte change after byte 0 is ignored for the current word
    dv0 = dv_count;
    send(8'h01, 1'b1);
    bus.one_byte = 1'b1;
    send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b1);
    check("toggle_word", bus.data_out, 32'h04030201);
    check("toggle_pulses", 32'(dv_count - dv0), 32'd1);

    // Random bytes, word sizes and occasional bad stop bits
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      logic       st;
      b            = 8'($urandom);
      st           = ($urandom_range(0, 9) != 0);
      bus.one_byte = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 20));
      send(b, st);
    end

    // Line already low when reset is released counts as a start bit
    do_reset(1'b0);
    bus.one_byte = 1'b1;
    send(8'h5A, 1'b1);
    check("low_after_reset", bus.data_out, 32'h0000005A);

    check("dv_fe_exclusive", 32'(both_count), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
